// File: rtl/controller_poller.sv
// rtl/controller_poller.sv - parallel serial game-controller poller; optional macro CONTROLLER_POLLER_EDGE_DETECT_EN adds pressed_list_o
module controller_poller #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int NUM_BITS        = 8,
  parameter int CLK_DIV         = 4,
  parameter int LATCH_TICKS     = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_fetch_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                ctrl_clk_o,
  output logic                                latch_o,
  input  logic [NUM_CONTROLLERS-1:0]          serial_list_ni,
  output logic [NUM_CONTROLLERS*NUM_BITS-1:0] data_list_o
`ifdef CONTROLLER_POLLER_EDGE_DETECT_EN
  ,
  output logic [NUM_CONTROLLERS*NUM_BITS-1:0] pressed_list_o
`endif
);

  localparam int W         = NUM_CONTROLLERS * NUM_BITS;
  localparam int LATCH_CYC = LATCH_TICKS * CLK_DIV;
  localparam int SLOT_CYC  = 2 * CLK_DIV;
  localparam int SHIFT_CYC = NUM_BITS * SLOT_CYC;
  localparam int CNT_MAX   = ((LATCH_CYC > SHIFT_CYC) ? LATCH_CYC : SHIFT_CYC) - 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, LATCH, GAP, SHIFT, DONE} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           latch_q, latch_d;
  logic                           ctrl_clk_q, ctrl_clk_d;
  logic [NUM_CONTROLLERS-1:0]     sync1_q, sync1_d;
  logic [NUM_CONTROLLERS-1:0]     sync2_q, sync2_d;
  logic [W-1:0]                   shift_q, shift_d;
  logic [W-1:0]                   data_q, data_d;
  logic [W-1:0]                   pressed_q, pressed_d;
  logic [NUM_CONTROLLERS-1:0]     in_bits;
  int                             slot_pos_q, slot_pos_d;
  logic                           sample, load;

  // Next-state logic: one cycle counter per state, cleared only when the state changes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_fetch_i) state_d = LATCH;
      end
      LATCH: begin
        if (cnt_q == CNT_W'(LATCH_CYC - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(SHIFT_CYC - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller-facing strobes are registered from the next state so the pins never glitch
  always_comb begin
    slot_pos_q = int'(cnt_q) % SLOT_CYC;
    slot_pos_d = int'(cnt_d) % SLOT_CYC;
    latch_d    = (state_d == LATCH);
    ctrl_clk_d = (state_d == SHIFT) && (slot_pos_d >= CLK_DIV);
    sample     = (state_q == SHIFT) && (slot_pos_q == CLK_DIV - 1);
    load       = (state_q == SHIFT) && (state_d == DONE);
  end

  // Synchronise, invert and shift in LSB-side; first bit sampled ends up in the MSB
  always_comb begin
    sync1_d = serial_list_ni;
    sync2_d = sync1_q;
    in_bits = ~sync2_q;
    shift_d = shift_q;
    if (sample) begin
      for (int c = 0; c < NUM_CONTROLLERS; c++) begin
        shift_d[c*NUM_BITS +: NUM_BITS] =
          (shift_q[c*NUM_BITS +: NUM_BITS] << 1) | NUM_BITS'(in_bits[c]);
      end
    end
  end

  // Output words change only on the transition into DONE, never mid-shift
  always_comb begin
    data_d    = data_q;
    pressed_d = pressed_q;
    if (load) begin
      data_d    = shift_q;
      pressed_d = shift_q & ~data_q;
    end
  end

  // State, counter and strobe registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      latch_q    <= 1'b0;
      ctrl_clk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      latch_q    <= latch_d;
      ctrl_clk_q <= ctrl_clk_d;
    end
  end

  // Synchroniser, shift register and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      pressed_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      pressed_q <= pressed_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign latch_o     = latch_q;
  assign ctrl_clk_o  = ctrl_clk_q;
  assign data_list_o = data_q;

`ifdef CONTROLLER_POLLER_EDGE_DETECT_EN
  assign pressed_list_o = pressed_q;
`else
  logic unused_pressed;
  assign unused_pressed = ^pressed_q;
`endif

endmodule

// File: tb/tb_controller_poller.sv
// tb/tb_controller_poller.sv - scoreboard bench for controller_poller with a behavioural controller model
module tb_controller_poller;

  localparam int NC  = 2;
  localparam int NB  = 8;
  localparam int CD  = 4;
  localparam int LT  = 2;
  localparam int W   = NC * NB;
  localparam int LAT = (LT + 1 + 2 * NB) * CD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, cclk, latch;
  logic [NC-1:0] serial_n;
  logic [W-1:0]  data;
  logic [W-1:0]  pressed;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int done_seen = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] pr;
    int           cyc;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] last_data = '0;
  logic [NB-1:0] pat [NC];
  logic [NB-1:0] sr  [NC] = '{default: '0};

  controller_poller #(
    .NUM_CONTROLLERS(NC), .NUM_BITS(NB), .CLK_DIV(CD), .LATCH_TICKS(LT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_fetch_i (start),
    .busy_o        (busy),
    .done_o        (done),
    .ctrl_clk_o    (cclk),
    .latch_o       (latch),
    .serial_list_ni(serial_n),
    .data_list_o   (data)
`ifdef CONTROLLER_POLLER_EDGE_DETECT_EN
    ,
    .pressed_list_o(pressed)
`endif
  );

`ifndef CONTROLLER_POLLER_EDGE_DETECT_EN
  assign pressed = '0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shift-register game pad: loads on latch, advances on each rising controller clock
  always @(posedge latch or posedge cclk) begin
    for (int c = 0; c < NC; c++) sr[c] <= latch ? pat[c] : (sr[c] << 1);
  end

  always_comb begin
    serial_n = '1;
    for (int c = 0; c < NC; c++) serial_n[c] = ~sr[c][NB-1];
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected result: button word as pressed, newly pressed relative to the previous result
  task automatic push_exp(input int exp_cyc);
    exp_t e;
    logic [W-1:0] d;
    for (int c = 0; c < NC; c++) d[c*NB +: NB] = pat[c];
    e.data    = d;
    e.pr      = d & ~last_data;
    e.cyc     = exp_cyc;
    last_data = d;
    sbq.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        done_seen++;
        check("sb_pending", (sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("data", data, e.data);
`ifdef CONTROLLER_POLLER_EDGE_DETECT_EN
          check("pressed", pressed, e.pr);
`endif
        end
      end
    end
  end

  // One poll started at the current negedge; optional extra request pulse mid-poll
  task automatic run_poll(input bit rnd, input int glitch_at);
    int issue, lcnt, rises, first_latch, d0;
    logic prev;
    bit seen;
    lcnt = 0; rises = 0; first_latch = -1; prev = 1'b0; seen = 1'b0;
    if (rnd) for (int c = 0; c < NC; c++) pat[c] = NB'($urandom);
    d0    = done_seen;
    issue = cyc;
    start = 1'b1;
    push_exp(issue + 1 + LAT);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < LAT + 20; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (latch) begin
        lcnt++;
        if (first_latch < 0) first_latch = cyc;
      end
      if (cclk && !prev) rises++;
      prev  = cclk;
      start = (glitch_at > 0 && cyc == issue + glitch_at) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_within_bound", seen, 1);
    check("latch_cycles", lcnt, LT * CD);
    check("latch_first", first_latch, issue + 1);
    check("ctrl_clk_rises", rises, NB);
    repeat ((glitch_at > 0) ? LAT + 10 : 3) @(negedge clk);
    check("done_count", done_seen - d0, 1);
    check("data_held", data, last_data);
  endtask

  initial begin
    int issue, nd, blow;
    for (int c = 0; c < NC; c++) pat[c] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ctrl_clk", cclk, 0);
    check("rst_latch", latch, 0);
    check("rst_data", data, 0);
    check("rst_pressed", pressed, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: controller 0 sends active-low 0101_1110, others idle high
    pat[0] = NB'('hA1);
    for (int c = 1; c < NC; c++) pat[c] = '0;
    run_poll(1'b0, 0);

    repeat (6) run_poll(1'b1, 0);

    // Request pulse mid-poll must be dropped
    run_poll(1'b1, 30);

    // Newly-pressed sequence 03 -> 06 -> 06
    for (int c = 0; c < NC; c++) pat[c] = NB'('h03);
    run_poll(1'b0, 0);
    for (int c = 0; c < NC; c++) pat[c] = NB'('h06);
    run_poll(1'b0, 0);
    run_poll(1'b0, 0);

    // Asynchronous reset in the middle of a poll
    for (int c = 0; c < NC; c++) pat[c] = NB'($urandom);
    issue = cyc;
    start = 1'b1;
    push_exp(issue + 1 + LAT);
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    check("busy_mid_poll", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ctrl_clk", cclk, 0);
    check("arst_latch", latch, 0);
    check("arst_data", data, 0);
    check("arst_pressed", pressed, 0);
    sbq.delete();
    last_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_poll(1'b1, 0);

    // Request held high: back-to-back polls with a single idle cycle between
    for (int c = 0; c < NC; c++) pat[c] = NB'($urandom);
    issue = cyc;
    start = 1'b1;
    push_exp(issue + 1 + LAT);
    push_exp(issue + 1 + 2 * LAT + 2);
    nd = 0;
    blow = 0;
    for (int k = 0; k < 2 * LAT + 40; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 2) begin
          start = 1'b0;
          break;
        end
      end else if (nd == 1 && !busy) begin
        blow++;
      end
    end
    start = 1'b0;
    check("b2b_dones", nd, 2);
    check("b2b_busy_low", blow, 1);
    repeat (5) @(negedge clk);
    check("b2b_idle", busy, 0);
    check("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
